issue_sb_ctrl: RTL
==================

Name: issue_sb_ctrl

Overview:
Issue controller between the decode queue and execute. Holds the register scoreboard and drains micro-ops in order. Each head micro-op issues only when its src0, src1 and dst file registers are all non-busy. On issue it marks dst busy, loads operand values, and presents the op on a registered output. Writebacks clear busy bits. Flush drains all in-flight ops before issue resumes.

Parameters:
MAX_INFLIGHT, 8, maximum issued-but-not-written-back ops; issue stalls when the count reaches it.
CNT_W, 32, width of the saturating stall-cycle counter.

Ports:
clk  in  1  core clock
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  decode queue head valid
in_mop  in  $bits(micro_op_t)  head micro-op (DecoderTypes)
in_ready  out  1  head consumed this cycle
reg_file  in  REG_FILE_SIZE*$bits(reg_val_t)  current register values
out_valid  out  1  issued op valid
out_mop  out  $bits(micro_op_t)  issued op, with src0_val/src1_val filled
out_ready  in  1  execute accepts
wb_valid  in  1  writeback occurring
wb_id  in  $bits(reg_id_t)  writeback destination
flush  in  1  pipeline flush request
busy_mask  out  REG_FILE_SIZE  scoreboard, index = reg_num
stall_cycles  out  CNT_W  cycles in which in_valid=1 and no issue happened

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous and active-low.
- Reset values: out_valid=0, out_mop=0, busy_mask=0, inflight=0, stall_cycles=0, state=RUN. in_ready is combinational and is 0 during reset.
- Reset mid-operation drops the output op and clears all scoreboard bits. No writeback completion is expected afterwards.
- FSM states: RUN and DRAIN.
- RUN to DRAIN on flush=1. DRAIN to RUN when busy_mask==0, inflight==0 and flush==0.
- Issue condition (RUN only): in_valid, all three checks pass, inflight<MAX_INFLIGHT, and the output slot is free (out_valid==0 or out_ready==1).
- Scoreboard check: check passes when the register is not in the file, or its busy bit is 0. Ids rnil, rip, rimm, rv0 and rv8 always pass.
- On issue: in_ready=1. out_mop <= in_mop, with src0_val/src1_val taken from the read_reg rules: rnil=0, rip=rip_val, rimm=immediate, rv0=0, rv8=8, file reg=reg_file entry. out_valid <= 1, dst busy bit set, inflight+1.
- Latency: issue to out_valid is 1 cycle. Back-to-back issue is allowed every cycle while out_ready=1.
- Output hold: when out_valid=1 and out_ready=0, out_mop holds stable and no new issue occurs.
- Writeback: wb_valid with an in-file wb_id clears that busy bit and decrements inflight. A non-file wb_id only decrements inflight.
- Same-cycle issue and writeback: both apply. inflight stays unchanged net.
- Same-cycle set and clear of the same bit: the set wins. This is only reachable with the optional feature enabled.
- Without the optional feature, the check uses the registered busy_mask only; a same-cycle writeback does not unblock.
- inflight underflow: a writeback with inflight==0 is ignored and fires a sim-only $display error.
- Flush: out_valid <= 0 next cycle and in_ready=0 while in DRAIN. Writebacks still clear bits. Busy bits are not force-cleared.
- stall_cycles saturates at all-ones and is not cleared by flush.

Optional Feature:
Macro: MUSK_ISSUE_WB_BYPASS_EN
- Defined: the check uses busy_mask & ~wb_mask, where wb_mask comes from wb_id. A waiting op issues in the same cycle as its producer's writeback. Operand values for wb_id are still read from reg_file, which the regfile writes through combinationally.
- Undefined: no bypass. Such an op issues 1 cycle later.

Decomposition:
- Add to RegMap (or a new IssueTypes package):
  - issue_state_t enum {RUN, DRAIN}
  - inflight width constant, $clog2(MAX_INFLIGHT+1)
- Reuse the existing scoreboard check, scoreboard-mask and register-load helpers from the core utilities package unchanged.
- One sub-module: issue_out_reg, a valid/ready holding register for out_mop.

Test Plan:
- Reset with in_valid=1: busy_mask=0, out_valid=0, in_ready=0 while reset_n=0. First op (dst = file reg 3) issues the cycle after release; busy_mask[3]=1 next cycle.
- RAW hazard: op A dst=reg3, then op B src0=reg3. B stalls with in_ready=0 and stall_cycles incrementing. Writeback wb_id=reg3 at cycle t: B issues at t+1 without bypass, at t with MUSK_ISSUE_WB_BYPASS_EN.
- Immediate sources: src0=rimm (immediate=0x1234), src1=rv8. out_mop.src0_val=0x1234, src1_val=8. No stall even when all busy bits are set.
- Backpressure: out_ready=0 for 5 cycles. out_mop stays stable, in_ready=0; release issues the next op 1 cycle later.
- MAX_INFLIGHT=8: issue 8 independent ops with no writeback; the 9th stalls until one writeback arrives.
- Flush with 3 in-flight: out_valid drops next cycle and state=DRAIN. Returns to RUN only after the 3rd writeback with flush=0.

Source files
------------

// File: rtl/issue_sb_ctrl_pkg.sv
// Shared types and helpers for the issue controller: register ids, micro-op layout,
// scoreboard check/mask helpers and operand read rules.
package issue_sb_ctrl_pkg;

    localparam int REG_FILE_SIZE = 8;
    localparam int RID_W         = $clog2(REG_FILE_SIZE);

    typedef logic [3:0]  reg_id_t;
    typedef logic [31:0] reg_val_t;
    typedef logic [REG_FILE_SIZE-1:0]        reg_mask_t;
    typedef logic [REG_FILE_SIZE-1:0][31:0] reg_file_t;

    // Ids at or above REG_FILE_SIZE never touch the scoreboard
    localparam reg_id_t RNIL = 4'd8;
    localparam reg_id_t RIP  = 4'd9;
    localparam reg_id_t RIMM = 4'd10;
    localparam reg_id_t RV0  = 4'd11;
    localparam reg_id_t RV8  = 4'd12;

    typedef struct packed {
        logic [5:0] opcode;
        reg_id_t    dst;
        reg_id_t    src0;
        reg_id_t    src1;
        reg_val_t   immediate;
        reg_val_t   rip_val;
        reg_val_t   src0_val;
        reg_val_t   src1_val;
    } micro_op_t;

    typedef enum logic {RUN, DRAIN} issue_state_t;

    function automatic int inflight_w(int max_inflight);
        return $clog2(max_inflight + 1);
    endfunction

    function automatic logic in_file(reg_id_t id);
        return id < reg_id_t'(REG_FILE_SIZE);
    endfunction

    function automatic logic sb_check(reg_id_t id, reg_mask_t busy);
        return !in_file(id) || !busy[id[RID_W-1:0]];
    endfunction

    function automatic reg_mask_t sb_mask(reg_id_t id);
        reg_mask_t m;
        m = '0;
        if (in_file(id)) m[id[RID_W-1:0]] = 1'b1;
        return m;
    endfunction

    function automatic reg_val_t read_reg(reg_id_t id, micro_op_t mop, reg_file_t rf);
        case (id)
            RNIL, RV0: return '0;
            RIP:       return mop.rip_val;
            RIMM:      return mop.immediate;
            RV8:       return reg_val_t'(8);
            default:   return in_file(id) ? rf[id[RID_W-1:0]] : '0;
        endcase
    endfunction

endpackage

// File: rtl/issue_sb_ctrl_if.sv
// Decode-side, execute-side, writeback and status signals of the issue controller.
interface issue_sb_ctrl_if #(parameter int CNT_W = 32);
    import issue_sb_ctrl_pkg::*;

    logic       in_valid;
    micro_op_t  in_mop;
    logic       in_ready;
    reg_file_t  reg_file;
    logic       out_valid;
    micro_op_t  out_mop;
    logic       out_ready;
    logic       wb_valid;
    reg_id_t    wb_id;
    logic       flush;
    reg_mask_t  busy_mask;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output in_valid, in_mop, reg_file, out_ready, wb_valid, wb_id, flush,
        input  in_ready, out_valid, out_mop, busy_mask, stall_cycles
    );

    modport slave (
        input  in_valid, in_mop, reg_file, out_ready, wb_valid, wb_id, flush,
        output in_ready, out_valid, out_mop, busy_mask, stall_cycles
    );

endinterface

// File: rtl/issue_sb_ctrl_out_reg.sv
// Valid/ready holding register for the issued micro-op; clear drops the op on flush.
module issue_out_reg
    import issue_sb_ctrl_pkg::*;
(
    input  logic      clk,
    input  logic      reset_n,
    input  logic      load,
    input  logic      clear,
    input  logic      ready,
    input  micro_op_t d,
    output logic      valid,
    output micro_op_t q
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid <= 1'b0;
            q     <= '0;
        end else begin
            if (clear)      valid <= 1'b0;
            else if (load)  valid <= 1'b1;
            else if (ready) valid <= 1'b0;
            if (load) q <= d;
        end
    end

endmodule

// File: rtl/issue_sb_ctrl.sv
// In-order issue controller with register scoreboard and flush drain.
// Optional same-cycle writeback bypass of the scoreboard check: MUSK_ISSUE_WB_BYPASS_EN.
module issue_sb_ctrl
    import issue_sb_ctrl_pkg::*;
#(
    parameter int MAX_INFLIGHT = 8,
    parameter int CNT_W        = 32
) (
    input logic            clk,
    input logic            reset_n,
    issue_sb_ctrl_if.slave sb
);

    localparam int IFL_W = inflight_w(MAX_INFLIGHT);
    localparam logic [IFL_W-1:0] MAX_IFL = IFL_W'(MAX_INFLIGHT);
    localparam logic [IFL_W-1:0] IFL_ONE = IFL_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    issue_state_t     state;
    logic [IFL_W-1:0] inflight;
    logic [CNT_W-1:0] stall;
    reg_mask_t        busy;
    reg_mask_t        wb_mask;
    reg_mask_t        chk_mask;
    logic             wb_eff;
    logic             regs_ok;
    logic             issue;
    micro_op_t        issue_mop;

    // A writeback with nothing in flight is spurious and changes nothing
    assign wb_eff  = sb.wb_valid && (inflight != '0);
    assign wb_mask = wb_eff ? sb_mask(sb.wb_id) : '0;

`ifdef MUSK_ISSUE_WB_BYPASS_EN
    assign chk_mask = busy & ~wb_mask;
`else
    assign chk_mask = busy;
`endif

    assign regs_ok = sb_check(sb.in_mop.src0, chk_mask) &&
                     sb_check(sb.in_mop.src1, chk_mask) &&
                     sb_check(sb.in_mop.dst,  chk_mask);

    // Flush blocks issue so a dropped op can never leave a dangling dst bit behind
    assign issue = reset_n && (state == RUN) && !sb.flush && sb.in_valid && regs_ok &&
                   (inflight < MAX_IFL) && (!sb.out_valid || sb.out_ready);

    always_comb begin
        issue_mop          = sb.in_mop;
        issue_mop.src0_val = read_reg(sb.in_mop.src0, sb.in_mop, sb.reg_file);
        issue_mop.src1_val = read_reg(sb.in_mop.src1, sb.in_mop, sb.reg_file);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= RUN;
            busy     <= '0;
            inflight <= '0;
            stall    <= '0;
        end else begin
            // Clear before set: a same-cycle set of the same bit wins
            busy <= (busy & ~wb_mask) | (issue ? sb_mask(sb.in_mop.dst) : '0);
            case ({issue, wb_eff})
                2'b10:   inflight <= inflight + IFL_ONE;
                2'b01:   inflight <= inflight - IFL_ONE;
                default: inflight <= inflight;
            endcase
            if (sb.in_valid && !issue && (stall != '1)) stall <= stall + CNT_ONE;
            case (state)
                RUN:     if (sb.flush) state <= DRAIN;
                DRAIN:   if ((busy == '0) && (inflight == '0) && !sb.flush) state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

    issue_out_reg u_out (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (issue),
        .clear   (sb.flush),
        .ready   (sb.out_ready),
        .d       (issue_mop),
        .valid   (sb.out_valid),
        .q       (sb.out_mop)
    );

    assign sb.in_ready     = issue;
    assign sb.busy_mask    = busy;
    assign sb.stall_cycles = stall;

`ifndef SYNTHESIS
    always @(posedge clk)
        if (reset_n && sb.wb_valid && (inflight == '0))
            $display("issue_sb_ctrl: error, writeback id %0d with nothing in flight", sb.wb_id);
`endif

endmodule
